// File: rtl/asteroid_lane_engine.sv
// rtl/asteroid_lane_engine.sv - multi-lane falling-asteroid game-state engine
module asteroid_lane_engine #(
   parameter int LANES         = 5,
   parameter int LANE_X0       = 208,
   parameter int LANE_PITCH    = 128,
   parameter int SIZE          = 32,
   parameter int TOP_Y         = 36,
   parameter int DEFENSE_Y     = 420,
   parameter int PLANET_Y      = 470,
   parameter int TICK_DIV      = 833333,
   parameter int STEP          = 2,
   parameter int BLAST_TICKS   = 30,
   parameter int RESPAWN_TICKS = 45,
   parameter int LIVES_INIT    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       HCounter,
   input  logic [9:0]       VCounter,
   input  logic [LANES-1:0] fire,
   output logic             draw_rock,
   output logic             draw_blast,
   output logic [7:0]       score,
   output logic [2:0]       lives,
   output logic             game_over
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = 16;

   typedef enum logic [1:0] {WAIT, FALL, BLAST} laneState_t;

   logic [1:0]       rstSync;
   logic             rstInt;
   logic [TW-1:0]    tickCnt;
   logic             tick;
   logic [LANES-1:0] f1, f2, f3, shot;
   logic [LANES-1:0] hit, impact, inRock, inBlast;
   logic [3:0]       nHits, nImpacts;
   logic [8:0]       scoreSum;
   logic [7:0]       scoreR, scoreNext;
   logic [2:0]       livesR, livesNext;
   logic             gameOver, drawRockR, drawBlastR;

   // Reset asserts immediately but releases two clocks later, aligned to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rstSync <= 2'b00;
      else        rstSync <= {rstSync[0], 1'b1};
   end
   assign rstInt = rstSync[1];

   assign tick = (tickCnt == TW'(TICK_DIV - 1)) && !gameOver;

   always_ff @(posedge clk or negedge rstInt) begin
      if (!rstInt)        tickCnt <= '0;
      else if (!gameOver) tickCnt <= tick ? '0 : tickCnt + TW'(1);
   end

   always_ff @(posedge clk or negedge rstInt) begin
      if (!rstInt) begin
         f1 <= '0;
         f2 <= '0;
         f3 <= '0;
      end else begin
         f1 <= fire;
         f2 <= f1;
         f3 <= f2;
      end
   end
   assign shot = f2 & ~f3;

   for (genvar i = 0; i < LANES; i++) begin : gLane
      localparam int X    = LANE_X0 + i * LANE_PITCH;
      localparam int STAG = i * (RESPAWN_TICKS / LANES);

      laneState_t    st, stNext;
      logic [9:0]    y, yNext, yStep;
      logic [CW-1:0] cnt, cntNext;
      logic [10:0]   yBot, yStepBot;
      logic          hitL, impactL, inBox;

      // The wait counter is preloaded so the first spawn happens after STAG ticks.
      always_ff @(posedge clk or negedge rstInt) begin
         if (!rstInt) begin
            st  <= WAIT;
            y   <= 10'(TOP_Y);
            cnt <= CW'(RESPAWN_TICKS - STAG);
         end else if (!gameOver) begin
            st  <= stNext;
            y   <= yNext;
            cnt <= cntNext;
         end
      end

      assign yStep    = y + 10'(STEP);
      assign yBot     = {1'b0, y} + 11'(SIZE);
      assign yStepBot = {1'b0, yStep} + 11'(SIZE);

      always_comb begin
         stNext  = st;
         yNext   = y;
         cntNext = cnt;
         hitL    = 1'b0;
         impactL = 1'b0;
         case (st)
            WAIT: begin
               if (cnt >= CW'(RESPAWN_TICKS)) begin
                  stNext  = FALL;
                  yNext   = 10'(TOP_Y);
                  cntNext = '0;
               end else if (tick) begin
                  cntNext = cnt + CW'(1);
               end
            end
            FALL: begin
               // Hit is judged on the pre-step position and beats both step and impact.
               if (shot[i] && (yBot >= 11'(DEFENSE_Y))) begin
                  hitL    = 1'b1;
                  stNext  = BLAST;
                  cntNext = '0;
               end else if (tick) begin
                  yNext = yStep;
                  if (yStepBot >= 11'(PLANET_Y)) begin
                     impactL = 1'b1;
                     stNext  = WAIT;
                     cntNext = '0;
                  end
               end
            end
            BLAST: begin
               if (tick) begin
                  if (cnt >= CW'(BLAST_TICKS - 1)) begin
                     stNext  = WAIT;
                     cntNext = '0;
                  end else begin
                     cntNext = cnt + CW'(1);
                  end
               end
            end
            default: stNext = WAIT;
         endcase
      end

      assign inBox = ({1'b0, HCounter} >= 11'(X)) && ({1'b0, HCounter} < 11'(X + SIZE)) &&
                     (VCounter >= y) && ({1'b0, VCounter} < yBot);

      assign hit[i]     = hitL;
      assign impact[i]  = impactL;
      assign inRock[i]  = inBox && (st == FALL);
      assign inBlast[i] = inBox && (st == BLAST);
   end

   always_comb begin
      nHits    = '0;
      nImpacts = '0;
      for (int k = 0; k < LANES; k++) begin
         nHits    = nHits + 4'(hit[k]);
         nImpacts = nImpacts + 4'(impact[k]);
      end
      scoreSum  = {1'b0, scoreR} + 9'(nHits);
      scoreNext = scoreSum[8] ? 8'hFF : scoreSum[7:0];
      livesNext = ({1'b0, livesR} > nImpacts) ? 3'({1'b0, livesR} - nImpacts) : 3'd0;
   end

   always_ff @(posedge clk or negedge rstInt) begin
      if (!rstInt) begin
         scoreR   <= '0;
         livesR   <= 3'(LIVES_INIT);
         gameOver <= 1'b0;
      end else if (!gameOver) begin
         scoreR   <= scoreNext;
         livesR   <= livesNext;
         gameOver <= (livesNext == 3'd0);
      end
   end

   // Drawing keeps running after game over so the frozen scene stays visible.
   always_ff @(posedge clk or negedge rstInt) begin
      if (!rstInt) begin
         drawRockR  <= 1'b0;
         drawBlastR <= 1'b0;
      end else begin
         drawRockR  <= |inRock;
         drawBlastR <= |inBlast;
      end
   end

   assign draw_rock  = drawRockR;
   assign draw_blast = drawBlastR;
   assign score      = scoreR;
   assign lives      = livesR;
   assign game_over  = gameOver;

endmodule

// File: tb/tb_asteroid_lane_engine.sv
// tb/tb_asteroid_lane_engine.sv - directed self-checking bench for asteroid_lane_engine
module tb_asteroid_lane_engine;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] HCounter = '0;
   logic [9:0] VCounter = '0;
   logic [4:0] fire = '0;
   logic       draw_rock, draw_blast, game_over;
   logic [7:0] score;
   logic [2:0] lives;

   int checks = 0;
   int errors = 0;
   int cur = 0;

   always #5 clk = ~clk;

   asteroid_lane_engine #(
      .LANES(5), .LANE_X0(208), .LANE_PITCH(128), .SIZE(32), .TOP_Y(36),
      .DEFENSE_Y(420), .PLANET_Y(470), .TICK_DIV(4), .STEP(16),
      .BLAST_TICKS(2), .RESPAWN_TICKS(5), .LIVES_INIT(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .HCounter(HCounter), .VCounter(VCounter), .fire(fire),
      .draw_rock(draw_rock), .draw_blast(draw_blast), .score(score), .lives(lives),
      .game_over(game_over)
   );

   // cur counts active edges since the first one that runs the game logic.
   task automatic step();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic advanceTo(input int n);
      while (cur < n) step();
   endtask

   // Draw flags sampled after this edge reflect state after edge cur-1.
   task automatic pix(input int h, input int v);
      HCounter = 10'(h);
      VCounter = 10'(v);
      step();
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      fire = '0;
      HCounter = '0;
      VCounter = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      cur = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      HCounter = 10'd208;
      VCounter = 10'd36;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
      checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", lives); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
      checks++; if (draw_rock !== 1'b0) begin errors++; $display("FAIL reset_draw_rock: got %b want 0", draw_rock); end
      checks++; if (draw_blast !== 1'b0) begin errors++; $display("FAIL reset_draw_blast: got %b want 0", draw_blast); end
   endtask

   task automatic test_spawn_fall();
      doReset();
      advanceTo(2);
      pix(208, 36);
      checks++; if (draw_rock !== 1'b1) begin errors++; $display("FAIL lane0_spawn: draw_rock=%b want 1", draw_rock); end
      pix(720, 36);
      checks++; if (draw_rock !== 1'b0) begin errors++; $display("FAIL lane4_not_yet: draw_rock=%b want 0", draw_rock); end
      advanceTo(17);
      pix(208, 131);
      checks++; if (draw_rock !== 1'b1) begin errors++; $display("FAIL lane0_y100_bottom: draw_rock=%b want 1", draw_rock); end
      pix(208, 132);
      checks++; if (draw_rock !== 1'b0) begin errors++; $display("FAIL lane0_y100_below: draw_rock=%b want 0", draw_rock); end
      pix(720, 36);
      checks++; if (draw_rock !== 1'b1) begin errors++; $display("FAIL lane4_spawn: draw_rock=%b want 1", draw_rock); end
      pix(208, 147);
      checks++; if (draw_rock !== 1'b1) begin errors++; $display("FAIL lane0_y116_bottom: draw_rock=%b want 1", draw_rock); end
      advanceTo(103);
      checks++; if (lives !== 3'd3) begin errors++; $display("FAIL lives_pre_impact: got %0d want 3", lives); end
      pix(208, 440);
      checks++; if (draw_rock !== 1'b1) begin errors++; $display("FAIL lane0_y436: draw_rock=%b want 1", draw_rock); end
      checks++; if (lives !== 3'd2) begin errors++; $display("FAIL lives_first_impact: got %0d want 2", lives); end
      pix(208, 460);
      checks++; if (draw_rock !== 1'b0) begin errors++; $display("FAIL lane0_back_to_wait: draw_rock=%b want 0", draw_rock); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL no_game_over_yet: got %b want 0", game_over); end
   endtask

   task automatic test_hit_window();
      doReset();
      advanceTo(84);
      fire = 5'b00001;
      advanceTo(87);
      fire = 5'b00000;
      advanceTo(88);
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL shot_above_window: score=%0d want 0", score); end
      advanceTo(92);
      fire = 5'b00001;
      advanceTo(95);
      checks++; if (score !== 8'd1) begin errors++; $display("FAIL shot_in_window: score=%0d want 1", score); end
      fire = 5'b00000;
      pix(208, 404);
      checks++; if (draw_blast !== 1'b1) begin errors++; $display("FAIL blast_top_row: draw_blast=%b want 1", draw_blast); end
      checks++; if (draw_rock !== 1'b0) begin errors++; $display("FAIL no_rock_in_blast: draw_rock=%b want 0", draw_rock); end
      pix(208, 400);
      checks++; if (draw_blast !== 1'b0) begin errors++; $display("FAIL blast_above_box: draw_blast=%b want 0", draw_blast); end
      advanceTo(99);
      pix(208, 435);
      checks++; if (draw_blast !== 1'b1) begin errors++; $display("FAIL blast_frozen_last_tick: draw_blast=%b want 1", draw_blast); end
      pix(208, 435);
      checks++; if (draw_blast !== 1'b0) begin errors++; $display("FAIL blast_ended: draw_blast=%b want 0", draw_blast); end
   endtask

   task automatic test_held_switch();
      doReset();
      fire = 5'b00010;
      advanceTo(94);
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL held_level_no_shot: score=%0d want 0", score); end
      fire = 5'b00000;
      advanceTo(96);
      fire = 5'b00010;
      advanceTo(99);
      checks++; if (score !== 8'd1) begin errors++; $display("FAIL held_first_edge: score=%0d want 1", score); end
      advanceTo(103);
      checks++; if (score !== 8'd1) begin errors++; $display("FAIL held_single_hit: score=%0d want 1", score); end
      fire = 5'b00000;
   endtask

   task automatic test_coincident();
      doReset();
      advanceTo(101);
      fire = 5'b00001;
      advanceTo(103);
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL coincident_pre: score=%0d want 0", score); end
      advanceTo(104);
      checks++; if (score !== 8'd1) begin errors++; $display("FAIL coincident_hit: score=%0d want 1", score); end
      checks++; if (lives !== 3'd3) begin errors++; $display("FAIL coincident_lives: got %0d want 3", lives); end
      pix(208, 436);
      checks++; if (draw_blast !== 1'b1) begin errors++; $display("FAIL coincident_prestep_y: draw_blast=%b want 1", draw_blast); end
      fire = 5'b00000;
   endtask

   task automatic test_multi_impact();
      doReset();
      advanceTo(94);
      fire = 5'b00111;
      advanceTo(97);
      checks++; if (score !== 8'd3) begin errors++; $display("FAIL triple_hit: score=%0d want 3", score); end
      advanceTo(110);
      fire = 5'b11111;
      advanceTo(113);
      checks++; if (score !== 8'd5) begin errors++; $display("FAIL double_hit: score=%0d want 5", score); end
      advanceTo(227);
      checks++; if (lives !== 3'd3) begin errors++; $display("FAIL lives_before_triple: got %0d want 3", lives); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL game_over_early: got %b want 0", game_over); end
      advanceTo(228);
      checks++; if (lives !== 3'd0) begin errors++; $display("FAIL triple_impact_lives: got %0d want 0", lives); end
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL triple_impact_game_over: got %b want 1", game_over); end
      fire = 5'b00000;
      advanceTo(232);
      fire = 5'b01000;
      advanceTo(260);
      checks++; if (score !== 8'd5) begin errors++; $display("FAIL frozen_score: score=%0d want 5", score); end
      checks++; if (lives !== 3'd0) begin errors++; $display("FAIL frozen_lives: got %0d want 0", lives); end
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL frozen_game_over: got %b want 1", game_over); end
      pix(592, 388);
      checks++; if (draw_rock !== 1'b1) begin errors++; $display("FAIL frozen_lane3_draw: draw_rock=%b want 1", draw_rock); end
      pix(720, 419);
      checks++; if (draw_rock !== 1'b1) begin errors++; $display("FAIL frozen_lane4_draw: draw_rock=%b want 1", draw_rock); end
      fire = 5'b00000;
   endtask

   task automatic test_reset_blast_saturate();
      doReset();
      advanceTo(94);
      fire = 5'b00001;
      advanceTo(97);
      fire = 5'b00000;
      pix(208, 420);
      checks++; if (draw_blast !== 1'b1) begin errors++; $display("FAIL blast_before_reset: draw_blast=%b want 1", draw_blast); end
      rst_n = 1'b0;
      #1;
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL midreset_score: got %0d want 0", score); end
      checks++; if (lives !== 3'd3) begin errors++; $display("FAIL midreset_lives: got %0d want 3", lives); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL midreset_game_over: got %b want 0", game_over); end
      checks++; if (draw_blast !== 1'b0) begin errors++; $display("FAIL midreset_draw_blast: got %b want 0", draw_blast); end
      checks++; if (draw_rock !== 1'b0) begin errors++; $display("FAIL midreset_draw_rock: got %b want 0", draw_rock); end
      doReset();
      advanceTo(50);
      force dut.scoreR = 8'd254;
      step();
      release dut.scoreR;
      #1;
      checks++; if (score !== 8'd254) begin errors++; $display("FAIL preset_score: got %0d want 254", score); end
      advanceTo(94);
      fire = 5'b00011;
      advanceTo(97);
      checks++; if (score !== 8'd255) begin errors++; $display("FAIL saturate_two_hits: got %0d want 255", score); end
      advanceTo(100);
      fire = 5'b00111;
      advanceTo(103);
      checks++; if (score !== 8'd255) begin errors++; $display("FAIL saturate_extra_hit: got %0d want 255", score); end
      fire = 5'b00000;
   endtask

   initial begin
      test_reset();
      test_spawn_fall();
      test_hit_window();
      test_held_switch();
      test_coincident();
      test_multi_impact();
      test_reset_blast_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
